// File: rtl/dm_dump_pkg.sv
// Shared types and constants for the data-memory dump reader.
package dm_dump_pkg;

  typedef enum logic [2:0] {IDLE, REQ, CAP, OUT, FIN} dump_state_t;

  localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/dm_dump_reader.sv
// Reads a contiguous range of data-memory words and streams them out with
// their index over valid/ready, accumulating a 32-bit running checksum.
module dm_dump_reader
  import dm_dump_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  output logic              DM_enable,
  output logic              DM_write,
  output logic [ADDR_W-1:0] DM_address,
  output logic [31:0]       DM_in,
  input  logic [31:0]       DM_out,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [31:0]       dout_data,
  output logic [CNT_W-1:0]  dout_index,
  output logic              busy,
  output logic              done,
  output logic [31:0]       checksum
);

  dump_state_t       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  remaining_q, remaining_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic [31:0]       data_q, data_d;
  logic [31:0]       csum_q, csum_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      idx_q       <= '0;
      data_q      <= '0;
      csum_q      <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      idx_q       <= idx_d;
      data_q      <= data_d;
      csum_q      <= csum_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    idx_d       = idx_q;
    data_d      = data_q;
    csum_d      = csum_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          csum_d = '0;
          if (word_count != '0) begin
            // Word-align the start address; DM ignores the byte offset anyway.
            addr_d      = base_addr & ~ADDR_W'(WORD_BYTES - 1);
            remaining_d = word_count;
            idx_d       = '0;
            state_d     = REQ;
          end else begin
            state_d = FIN;
          end
        end
      end
      REQ: state_d = CAP;
      CAP: begin
        data_d  = DM_out;
        csum_d  = csum_q + DM_out;
        state_d = OUT;
      end
      OUT: begin
        if (dout_ready) begin
          idx_d       = idx_q + CNT_W'(1);
          addr_d      = addr_q + ADDR_W'(WORD_BYTES);
          remaining_d = remaining_q - CNT_W'(1);
          state_d     = (remaining_q > CNT_W'(1)) ? REQ : FIN;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Every output comes from registered state; dout_ready only steers next-state.
  assign DM_enable  = (state_q == REQ);
  assign DM_write   = 1'b0;
  assign DM_address = addr_q;
  assign DM_in      = '0;
  assign dout_valid = (state_q == OUT);
  assign dout_data  = data_q;
  assign dout_index = idx_q;
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == FIN);
  assign checksum   = csum_q;

endmodule
